curve25519_arbiter: RTL and testbench



---
 rtl/curve25519_arbiter_if.sv | 42 ++++
 rtl/curve25519_arbiter.sv | 153 +++++++++++++++
 tb/tb_curve25519_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/curve25519_arbiter_if.sv
// Bus bundle between the curve25519 arbiter, its requesters and the shared core.
// Macro CURVE25519_ARB_CLAMP_EN has no effect here; it only alters the arbiter.
// Signals:
//   req_valid/req_ready/req_scalar/req_point : per-requester job channel
//   rsp_valid/rsp_ready/rsp_out              : per-requester result channel
//   core_start/core_scalar/core_point        : arbiter -> core
//   core_done/core_out                       : core -> arbiter
//   busy/grant_id                            : arbiter status
// Modports: slave = arbiter view, master = environment (requesters + core) view.
interface curve25519_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  localparam int unsigned SW = 255;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*SW-1:0] req_scalar;
  logic [NREQ*SW-1:0] req_point;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [SW-1:0]      rsp_out;
  logic               core_start;
  logic [SW-1:0]      core_scalar;
  logic [SW-1:0]      core_point;
  logic               core_done;
  logic [SW-1:0]      core_out;
  logic               busy;
  logic [IDW-1:0]     grant_id;

  modport slave (
    input  req_valid, req_scalar, req_point, rsp_ready, core_done, core_out,
    output req_ready, rsp_valid, rsp_out, core_start, core_scalar, core_point,
           busy, grant_id
  );

  modport master (
    output req_valid, req_scalar, req_point, rsp_ready, core_done, core_out,
    input  req_ready, rsp_valid, rsp_out, core_start, core_scalar, core_point,
           busy, grant_id
  );
endinterface

// File: rtl/curve25519_arbiter.sv
// Round-robin arbiter sharing one curve25519 scalar-multiplication core among
// NREQ requesters. One job in flight: grant in IDLE, one-cycle start pulse,
// wait for the core to drop and re-raise done, then hand the result back to
// the owner over its response channel.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : job/response channels, core handshake, busy and grant_id
// Optional build macro CURVE25519_ARB_CLAMP_EN: when defined, the accepted
// scalar is clamped (bits [2:0] cleared, bit 254 set) before reaching the core.
// req_ready is the only combinational output; it is driven in the grant cycle.
module curve25519_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  curve25519_arbiter_if.slave   bus
);
  localparam int unsigned SW = 255;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

  state_t          state, state_next;
  logic [IDW-1:0]  rr_ptr, rr_next;
  logic [IDW-1:0]  grant_q, grant_next;
  logic [SW-1:0]   scalar_q, scalar_next;
  logic [SW-1:0]   point_q, point_next;
  logic [SW-1:0]   rsp_out_q, rsp_out_next;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_next;
  logic [NREQ-1:0] req_ready_c;
  logic            start_q, start_next;
  logic            busy_q, busy_next;

  logic            found_c;
  logic [IDW-1:0]  win_c;
  logic [SW-1:0]   win_scalar_c, win_point_c;
  logic [NREQ-1:0] valid_sh;
  int unsigned     cand;

  // Scalar conditioning applied on acceptance.
  function automatic logic [SW-1:0] clamp_scalar(input logic [SW-1:0] s);
`ifdef CURVE25519_ARB_CLAMP_EN
    clamp_scalar = (s & {1'b0, {(SW-4){1'b1}}, 3'b000}) | {1'b1, {(SW-1){1'b0}}};
`else
    clamp_scalar = s;
`endif
  endfunction

  // Round-robin search starting just after the last owner.
  always_comb begin : rr_search
    found_c      = 1'b0;
    win_c        = '0;
    cand         = 0;
    valid_sh     = '0;
    win_scalar_c = '0;
    win_point_c  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(rr_ptr) + k) % NREQ;
      valid_sh = bus.req_valid >> cand;
      if (!found_c && valid_sh[0]) begin
        found_c = 1'b1;
        win_c   = IDW'(cand);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_c) begin
        win_scalar_c = bus.req_scalar[i*SW +: SW];
        win_point_c  = bus.req_point[i*SW +: SW];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin : fsm_next
    state_next     = state;
    rr_next        = rr_ptr;
    grant_next     = grant_q;
    scalar_next    = scalar_q;
    point_next     = point_q;
    rsp_valid_next = rsp_valid_q;
    rsp_out_next   = rsp_out_q;
    req_ready_c    = '0;

    unique case (state)
      IDLE: begin
        // A core left running across reset holds off any grant until done.
        if (bus.core_done && found_c) begin
          req_ready_c = NREQ'(1) << win_c;
          scalar_next = clamp_scalar(win_scalar_c);
          point_next  = win_point_c;
          grant_next  = win_c;
          rr_next     = win_c;
          state_next  = ISSUE;
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      // Ignore a done left over from the previous operation.
      WAIT_BUSY: if (!bus.core_done) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.core_done) begin
          rsp_out_next   = bus.core_out;
          rsp_valid_next = NREQ'(1) << grant_q;
          state_next     = RESPOND;
        end
      end
      RESPOND: begin
        // rsp_valid is one-hot on the owner, so this sees only its ready.
        if ((bus.rsp_ready & rsp_valid_q) != '0) begin
          rsp_valid_next = '0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    start_next = (state_next == ISSUE);
    busy_next  = (state_next != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= IDW'(NREQ - 1);
      grant_q     <= '0;
      scalar_q    <= '0;
      point_q     <= '0;
      rsp_out_q   <= '0;
      rsp_valid_q <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_next;
      grant_q     <= grant_next;
      scalar_q    <= scalar_next;
      point_q     <= point_next;
      rsp_out_q   <= rsp_out_next;
      rsp_valid_q <= rsp_valid_next;
      start_q     <= start_next;
      busy_q      <= busy_next;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_out     = rsp_out_q;
  assign bus.core_start  = start_q;
  assign bus.core_scalar = scalar_q;
  assign bus.core_point  = point_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
endmodule

// File: tb/tb_curve25519_arbiter.sv
// Bench for curve25519_arbiter: a stand-in core with programmable stale-done
// and latency, directed phases plus randomized rounds, and a reference model
// predicting grant order and results from the arbitration rules.
module tb_curve25519_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned SW   = 255;
  localparam logic [SW-1:0] STALE_OUT = 255'h5a5a_dead_beef_0bad_cafe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  curve25519_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  curve25519_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clock(clock), .reset(reset), .bus(bus));

  // Stand-in for the scalar multiplication result.
  function automatic logic [SW-1:0] core_fn(input logic [SW-1:0] s, input logic [SW-1:0] p);
    core_fn = (s + SW'(3) * p) ^ {p[126:0], p[254:127]};
  endfunction

  function automatic logic [SW-1:0] exp_scalar(input logic [SW-1:0] s);
`ifdef CURVE25519_ARB_CLAMP_EN
    logic [SW-1:0] v;
    v = s;
    v[2:0] = 3'b000;
    v[254] = 1'b1;
    exp_scalar = v;
`else
    exp_scalar = s;
`endif
  endfunction

  function automatic logic [SW-1:0] rand255();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    return v[SW-1:0];
  endfunction

  // Core model: done stays high for stale_run cycles after start, then low for
  // lat_run cycles, then high with the new result; unaffected by arbiter reset.
  int stale_cfg = 0, lat_cfg = 6;
  int stale_run = 0, lat_run = 0, t = 0;
  logic run = 1'b0;
  logic [SW-1:0] res = '0;
  logic [SW-1:0] out_m = STALE_OUT;
  always @(posedge clock) begin
    if (bus.core_start) begin
      run <= 1'b1; t <= 0; stale_run <= stale_cfg; lat_run <= lat_cfg;
      res <= core_fn(bus.core_scalar, bus.core_point);
    end else if (run) begin
      t <= t + 1;
      if (t + 1 >= stale_run + lat_run) begin
        run <= 1'b0; out_m <= res;
      end
    end
  end
  assign bus.core_done = !run || (t < stale_run);
  assign bus.core_out  = out_m;

  int total = 0, bad = 0, cyc = 0, start_cnt = 0, viol = 0;
  int last_hs_cyc = -1, last_start_cyc = -1;
  int last_g = NREQ - 1;
  logic [NREQ-1:0] hs_pend = '0, keep = '0;
  logic [SW-1:0] job_sc[NREQ], job_pt[NREQ];
  int hs_idx[$], rsp_idx[$], exp_order[$];
  logic [SW-1:0] hs_sc[$], hs_pt[$], st_sc[$], rsp_val[$];

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_jobs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_scalar[i*SW +: SW] = job_sc[i];
      bus.req_point[i*SW +: SW]  = job_pt[i];
    end
  endtask

  // Sampled one time unit before each rising edge.
  task automatic observe();
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          hs_idx.push_back(i); hs_sc.push_back(job_sc[i]); hs_pt.push_back(job_pt[i]);
          hs_pend[i] = 1'b1; last_hs_cyc = cyc;
        end
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          rsp_idx.push_back(i); rsp_val.push_back(bus.rsp_out);
        end
      end
      if (bus.core_start) begin
        start_cnt++; st_sc.push_back(bus.core_scalar); last_start_cyc = cyc;
      end
      if (!$onehot0(bus.rsp_valid) || !$onehot0(bus.req_ready)) viol++;
      if (bus.busy && (bus.req_ready != '0)) viol++;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    #4;
    observe();
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_pend[i]) begin
        hs_pend[i] = 1'b0;
        if (keep[i]) begin job_sc[i] = rand255(); job_pt[i] = rand255(); end
        else bus.req_valid[i] = 1'b0;
      end
    end
    drive_jobs();
    @(negedge clock);
  endtask

  task automatic clear_all();
    hs_idx.delete(); rsp_idx.delete(); exp_order.delete();
    hs_sc.delete(); hs_pt.delete(); st_sc.delete(); rsp_val.delete();
    hs_pend = '0; last_g = NREQ - 1;
  endtask

  task automatic run_until(input int n, input int budget, input bit rand_ack, input string tag);
    int k = 0;
    while (rsp_idx.size() < n && k < budget) begin
      if (rand_ack) bus.rsp_ready = NREQ'($urandom);
      step();
      k++;
    end
    bus.rsp_ready = '0;
    chk(tag, SW'(rsp_idx.size()), SW'(n));
  endtask

  function automatic int rr_model(input int last, input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Service order when the whole mask is raised together at an idle arbiter.
  task automatic plan(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] m;
    int g;
    m = mask;
    while (m != '0) begin
      g = rr_model(last_g, m);
      exp_order.push_back(g);
      m[g] = 1'b0;
      last_g = g;
    end
  endtask

  task automatic check_sb(input int njobs);
    chk("sb_handshakes", SW'(hs_idx.size()), SW'(njobs));
    chk("sb_starts", SW'(st_sc.size()), SW'(njobs));
    chk("sb_responses", SW'(rsp_idx.size()), SW'(njobs));
    for (int k = 0; k < njobs && k < hs_idx.size() && k < rsp_idx.size() && k < st_sc.size(); k++) begin
      if (k < exp_order.size()) chk("sb_grant_order", SW'(hs_idx[k]), SW'(exp_order[k]));
      chk("sb_rsp_owner", SW'(rsp_idx[k]), SW'(hs_idx[k]));
      chk("sb_rsp_value", rsp_val[k], core_fn(exp_scalar(hs_sc[k]), hs_pt[k]));
      chk("sb_core_scalar", st_sc[k], exp_scalar(hs_sc[k]));
    end
    hs_idx.delete(); rsp_idx.delete(); exp_order.delete();
    hs_sc.delete(); hs_pt.delete(); st_sc.delete(); rsp_val.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, SW'(bus.rsp_valid), '0);
    chk({tag, "_rsp_out"}, bus.rsp_out, '0);
    chk({tag, "_core_start"}, SW'(bus.core_start), '0);
    chk({tag, "_core_scalar"}, bus.core_scalar, '0);
    chk({tag, "_core_point"}, bus.core_point, '0);
    chk({tag, "_busy"}, SW'(bus.busy), '0);
    chk({tag, "_grant_id"}, SW'(bus.grant_id), '0);
    chk({tag, "_req_ready"}, SW'(bus.req_ready), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, hold_bad, starts0;
    logic [SW-1:0] snap, expc;
    logic [NREQ-1:0] mask;

    bus.req_valid = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin job_sc[i] = '0; job_pt[i] = '0; end
    drive_jobs();
    @(negedge clock);

    // Reset values.
    reset = 1'b1;
    step(); step();
    chk_zero_outputs("rst");
    reset = 1'b0;
    clear_all();

    // Single job from requester 0.
    job_sc[0] = {1'b1, 251'h1, 3'b000};
    job_pt[0] = SW'(9);
    drive_jobs();
    bus.req_valid = 4'b0001;
    plan(4'b0001);
    k = 0;
    while (hs_idx.size() < 1 && k < 5) begin step(); k++; end
    chk("p1_handshake", SW'(hs_idx.size()), SW'(1));
    step();
    chk("p1_start_latency", SW'(last_start_cyc - last_hs_cyc), SW'(1));
    k = 0;
    while (bus.rsp_valid == '0 && k < 40) begin step(); k++; end
    chk("p1_rsp_valid", SW'(bus.rsp_valid), SW'(4'b0001));
    chk("p1_rsp_out", bus.rsp_out, core_fn(exp_scalar({1'b1, 251'h1, 3'b000}), SW'(9)));
    chk("p1_busy", SW'(bus.busy), SW'(1));
    bus.rsp_ready = 4'b0001;
    run_until(1, 5, 1'b0, "p1_rsp_done");
    chk("p1_idle_after", SW'(bus.busy), '0);
    check_sb(1);

    // Contention: all requesters valid out of reset, results accepted at once.
    reset = 1'b1;
    keep = '1;
    for (int i = 0; i < NREQ; i++) begin job_sc[i] = rand255(); job_pt[i] = rand255(); end
    drive_jobs();
    bus.req_valid = '1;
    step(); step();
    reset = 1'b0;
    clear_all();
    exp_order = {0, 1, 2, 3, 0};
    bus.rsp_ready = '1;
    run_until(5, 200, 1'b0, "p2_done");
    bus.req_valid = '0;
    keep = '0;
    check_sb(5);
    last_g = 0;

    // Backpressure on requester 2 while others wait.
    job_sc[2] = rand255(); job_pt[2] = rand255(); drive_jobs();
    bus.req_valid = 4'b0100;
    plan(4'b0100);
    k = 0;
    while (bus.rsp_valid == '0 && k < 60) begin step(); k++; end
    chk("p3_rsp_valid", SW'(bus.rsp_valid), SW'(4'b0100));
    snap = bus.rsp_out;
    starts0 = start_cnt;
    for (int i = 0; i < 2; i++) begin job_sc[i] = rand255(); job_pt[i] = rand255(); end
    drive_jobs();
    bus.req_valid = bus.req_valid | 4'b0011;
    bus.rsp_ready = 4'b1011;
    hold_bad = 0;
    repeat (20) begin
      step();
      if (bus.rsp_out !== snap || bus.req_ready != '0 || bus.rsp_valid !== 4'b0100) hold_bad++;
    end
    chk("p3_hold_stable", SW'(hold_bad), '0);
    chk("p3_no_start_held", SW'(start_cnt - starts0), '0);
    plan(4'b0011);
    bus.rsp_ready = '1;
    run_until(3, 100, 1'b0, "p3_done");
    check_sb(3);

    // Stale done: core keeps done high for 3 cycles after start.
    stale_cfg = 3;
    job_sc[3] = rand255(); job_pt[3] = rand255(); drive_jobs();
    bus.req_valid = 4'b1000;
    plan(4'b1000);
    bus.rsp_ready = '1;
    snap = bus.core_out;
    run_until(1, 60, 1'b0, "p4_done");
    if (rsp_val.size() > 0) chk("p4_not_previous_out", SW'(rsp_val[0] !== snap), SW'(1));
    check_sb(1);
    stale_cfg = 0;

    // Reset mid-job while the core is busy.
    lat_cfg = 20;
    job_sc[1] = rand255(); job_pt[1] = rand255(); drive_jobs();
    bus.req_valid = 4'b0010;
    starts0 = start_cnt;
    k = 0;
    while (start_cnt == starts0 && k < 10) begin step(); k++; end
    chk("p5_started", SW'(start_cnt - starts0), SW'(1));
    repeat (5) step();
    chk("p5_core_busy", SW'(bus.core_done), '0);
    job_sc[0] = rand255(); job_pt[0] = rand255();
    job_sc[2] = rand255(); job_pt[2] = rand255();
    drive_jobs();
    bus.req_valid = 4'b0101;
    reset = 1'b1;
    step();
    chk_zero_outputs("p5_rst");
    reset = 1'b0;
    clear_all();
    lat_cfg = 6;
    k = 0;
    while (!bus.core_done && k < 40) begin step(); k++; end
    chk("p5_core_done_back", SW'(bus.core_done), SW'(1));
    chk("p5_no_grant_while_busy", SW'(hs_idx.size()), '0);
    exp_order = {0, 2};
    last_g = 2;
    bus.rsp_ready = '1;
    run_until(2, 100, 1'b0, "p5_done");
    check_sb(2);

    // Randomized rounds with random response acceptance and core timing.
    repeat (6) begin
      mask = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        if (mask[i]) begin job_sc[i] = rand255(); job_pt[i] = rand255(); end
      drive_jobs();
      stale_cfg = $urandom_range(0, 2);
      lat_cfg = $urandom_range(2, 8);
      bus.req_valid = mask;
      plan(mask);
      n = $countones(mask);
      run_until(n, 80 * n, 1'b1, "p6_round");
      check_sb(n);
    end
    stale_cfg = 0;
    lat_cfg = 6;

    // Clamp boundary from requester 1.
    job_sc[1] = SW'(7); job_pt[1] = SW'(9); drive_jobs();
    bus.req_valid = 4'b0010;
    plan(4'b0010);
    bus.rsp_ready = '1;
    run_until(1, 40, 1'b0, "p7_done");
`ifdef CURVE25519_ARB_CLAMP_EN
    expc = SW'(1) << 254;
`else
    expc = SW'(7);
`endif
    if (st_sc.size() > 0) chk("p7_core_scalar", st_sc[0], expc);
    check_sb(1);

    chk("protocol_violations", SW'(viol), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
